// File: rtl/wb_fb_pkg.sv
// Shared types and default geometry for the framebuffer Wishbone responder.
package wb_fb_pkg;
  localparam int FB_DEPTH  = 16000;
  localparam int FB_AWIDTH = 14;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  typedef struct packed {
    logic valid;
    logic we;
    logic oor;
  } pipe_t;
endpackage

// File: rtl/wb_fb_responder_if.sv
// Wishbone B4 pipelined bus bundle; dat_w is master->slave, dat_r is slave->master.
interface if_wb;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        ack;
  logic        stall;

  modport master (output cyc, stb, we, sel, adr, dat_w, input dat_r, ack, stall);
  modport slave  (input cyc, stb, we, sel, adr, dat_w, output dat_r, ack, stall);
endinterface

// File: rtl/wb_fb_responder_fb_ram.sv
// Single-port synchronous framebuffer RAM: DEPTH x 32, byte enables, registered read.
module fb_ram
  import wb_fb_pkg::*;
#(
  parameter int AWIDTH = FB_AWIDTH,
  parameter int DEPTH  = FB_DEPTH
) (
  input  logic              clk_i,
  input  logic              en,
  input  logic              we,
  input  logic [3:0]        sel,
  input  logic [AWIDTH-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);
  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (sel[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end else begin
        rdata <= mem[addr];
      end
    end
  end
endmodule

// File: rtl/wb_fb_responder.sv
// Pipelined Wishbone slave for the 8bpp framebuffer: in-order acks at fixed LATENCY.
// Define FB_CLEAR_EN to add the hardware fill engine (clear_i/clear_val_i/busy_o).
module wb_fb_responder
  import wb_fb_pkg::*;
#(
  parameter int AWIDTH  = FB_AWIDTH,
  parameter int DEPTH   = FB_DEPTH,
  parameter int LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  if_wb.slave         bus
`ifdef FB_CLEAR_EN
  ,
  input  logic        clear_i,
  input  logic [31:0] clear_val_i,
  output logic        busy_o
`endif
);
  logic [AWIDTH-1:0] idx;
  logic              oor, acc;
  pipe_t             in_ent;
  pipe_t [LATENCY:1] pipe;
  logic              ram_en, ram_we;
  logic [3:0]        ram_sel;
  logic [AWIDTH-1:0] ram_addr;
  logic [31:0]       ram_wdata, ram_rdata, rd_out;
  logic              unused_adr;

  assign idx        = bus.adr[AWIDTH+1:2];
  assign oor        = int'({1'b0, idx}) >= DEPTH;
  assign acc        = bus.cyc && bus.stb && !bus.stall;
  assign in_ent     = '{valid: acc, we: bus.we, oor: oor};
  assign unused_adr = ^{bus.adr[31:AWIDTH+2], bus.adr[1:0]};

  // Dropping cyc flushes everything in flight; requests re-issued with cyc survive.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)        pipe <= '0;
    else if (!bus.cyc) pipe <= '0;
    else begin
      pipe[1] <= in_ent;
      for (int k = 2; k <= LATENCY; k++) pipe[k] <= pipe[k-1];
    end
  end

  assign bus.ack = bus.cyc && pipe[LATENCY].valid;

  // Writes commit a cycle before any following read, so the RAM already holds merged bytes.
  assign rd_out = (pipe[1].valid && !pipe[1].we && !pipe[1].oor) ? ram_rdata : '0;

  if (LATENCY == 1) begin : g_lat1
    assign bus.dat_r = bus.cyc ? rd_out : '0;
  end else begin : g_latn
    logic [LATENCY:2][31:0] dpipe;
    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)        dpipe <= '0;
      else if (!bus.cyc) dpipe <= '0;
      else begin
        dpipe[2] <= rd_out;
        for (int k = 3; k <= LATENCY; k++) dpipe[k] <= dpipe[k-1];
      end
    end
    assign bus.dat_r = bus.cyc ? dpipe[LATENCY] : '0;
  end

`ifdef FB_CLEAR_EN
  state_t            state;
  logic              pend, pipe_empty;
  logic [AWIDTH-1:0] cidx;
  logic [31:0]       cval;

  always_comb begin
    pipe_empty = 1'b1;
    for (int k = 1; k <= LATENCY; k++) if (pipe[k].valid) pipe_empty = 1'b0;
  end

  assign bus.stall = pend || (state == S_CLEAR);
  assign busy_o    = (state == S_CLEAR);

  // Fill starts only once outstanding acks have drained; stall holds new traffic off meanwhile.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= S_IDLE;
      pend  <= 1'b0;
      cidx  <= '0;
      cval  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (clear_i && !pend) cval <= clear_val_i;
          if ((clear_i || pend) && pipe_empty && !acc) begin
            state <= S_CLEAR;
            pend  <= 1'b0;
            cidx  <= '0;
          end else if (clear_i) begin
            pend <= 1'b1;
          end
        end
        S_CLEAR: begin
          cidx <= cidx + 1'b1;
          if (cidx == AWIDTH'(DEPTH - 1)) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
`else
  assign bus.stall = 1'b0;
`endif

  always_comb begin
    ram_en    = acc && !oor;
    ram_we    = bus.we;
    ram_sel   = bus.sel;
    ram_addr  = idx;
    ram_wdata = bus.dat_w;
`ifdef FB_CLEAR_EN
    if (state == S_CLEAR) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_sel   = 4'hF;
      ram_addr  = cidx;
      ram_wdata = cval;
    end
`endif
  end

  fb_ram #(.AWIDTH(AWIDTH), .DEPTH(DEPTH)) u_ram (
    .clk_i (clk_i),
    .en    (ram_en),
    .we    (ram_we),
    .sel   (ram_sel),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );
endmodule
